// File: rtl/i2c_seq_pkg.sv
// rtl/i2c_seq_pkg.sv - shared state encoding and constants for the I2C command sequencer
package i2c_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    PUSH    = 2'd3
  } seq_state_t;

  // Legacy command word bit that marks a read transaction
  localparam int RD_VALID_BIT = 31;

  // Result word reported when a read never completes
  localparam logic [31:0] DEFAULT_TIMEOUT_VALUE = 32'hdeadf00d;

endpackage

// File: rtl/i2c_seq_fifo.sv
// rtl/i2c_seq_fifo.sv - 32-bit synchronous FIFO with registered head word, level and clear
module i2c_seq_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [31:0]              wdata,
  input  logic                     pop,
  output logic [31:0]              rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (level_q == LVL_FULL);
  assign empty   = (level_q == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rdata   = rdata_q;
  assign level   = level_q;

  // Pointer/level bookkeeping; the head register always holds the oldest word
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    rdata_d  = rdata_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      level_d = level_q + LW'(do_push) - LW'(do_pop);
      if (do_pop) begin
        if (level_q == LVL_ONE) begin
          if (do_push) rdata_d = wdata;
        end else begin
          rdata_d = mem_q[rd_ptr_q + PTR_ONE];
        end
      end else if (do_push && empty) begin
        rdata_d = wdata;
      end
    end
  end

  // Storage array write; contents need no reset since level gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Control and head register state
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// rtl/i2c_cmd_sequencer.sv - command queue and readback collector for the I2C engine; watchdog under I2C_CMD_SEQ_TIMEOUT_EN
module i2c_cmd_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int          CMD_DEPTH      = 16,
  parameter int          RES_DEPTH      = 8,
  parameter int          TIMEOUT_CYCLES = 2**20,
  parameter logic [31:0] TIMEOUT_VALUE  = DEFAULT_TIMEOUT_VALUE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         s_cmd_valid,
  input  logic [31:0]                  s_cmd_data,
  output logic                         s_cmd_ready,
  output logic                         m_cmd_valid,
  output logic [31:0]                  m_cmd_data,
  input  logic                         m_cmd_ready,
  input  logic                         s_int_valid,
  output logic                         s_int_ready,
  input  logic [31:0]                  s_rb_data,
  output logic                         m_res_valid,
  output logic [31:0]                  m_res_data,
  input  logic                         m_res_ready,
  output logic [$clog2(CMD_DEPTH):0]   cmd_level,
  output logic [$clog2(RES_DEPTH):0]   res_level,
  output logic                         busy,
  output logic                         timeout_flag
);

  seq_state_t  state_q, state_d;
  logic [31:0] cmd_q, cmd_d;
  logic [31:0] rb_q, rb_d;
  logic        cmd_pop;
  logic        res_push;
  logic [31:0] cmd_rdata;
  logic        cmd_full, cmd_empty;
  logic        res_full, res_empty;
  logic        wd_expired;

  i2c_seq_fifo #(.DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (s_cmd_valid && s_cmd_ready),
    .wdata (s_cmd_data),
    .pop   (cmd_pop),
    .rdata (cmd_rdata),
    .level (cmd_level),
    .full  (cmd_full),
    .empty (cmd_empty)
  );

  i2c_seq_fifo #(.DEPTH(RES_DEPTH)) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .push  (res_push),
    .wdata (rb_q),
    .pop   (m_res_ready),
    .rdata (m_res_data),
    .level (res_level),
    .full  (res_full),
    .empty (res_empty)
  );

  assign s_cmd_ready = !cmd_full;
  assign m_cmd_valid = (state_q == ISSUE);
  assign m_cmd_data  = cmd_q;
  assign s_int_ready = (state_q == WAIT_RD);
  assign m_res_valid = !res_empty;
  assign busy        = (state_q != IDLE) || !cmd_empty;

`ifdef I2C_CMD_SEQ_TIMEOUT_EN
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic        flag_q;

  assign wd_expired   = (state_q == WAIT_RD) && !s_int_valid && (wd_cnt_q == WD_LAST);
  assign timeout_flag = flag_q;

  // Watchdog only counts in WAIT_RD, so it is zero on every entry
  always_comb begin
    wd_cnt_d = '0;
    if (state_q == WAIT_RD) wd_cnt_d = wd_cnt_q + 32'd1;
  end

  // Watchdog counter and sticky expiry flag; expiry wins over a same-cycle flush
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      if (wd_expired)  flag_q <= 1'b1;
      else if (flush)  flag_q <= 1'b0;
    end
  end
`else
  logic unused_wd_cfg;

  assign wd_expired    = 1'b0;
  assign timeout_flag  = 1'b0;
  assign unused_wd_cfg = ^32'(TIMEOUT_CYCLES);
`endif

  // Sequencer: fetch one command, present it, then collect readback for reads
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    rb_d     = rb_q;
    cmd_pop  = 1'b0;
    res_push = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!cmd_empty && !flush) begin
          cmd_pop = 1'b1;
          cmd_d   = cmd_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (m_cmd_ready) state_d = cmd_q[RD_VALID_BIT] ? WAIT_RD : IDLE;
      end
      WAIT_RD: begin
        if (s_int_valid) begin
          rb_d    = s_rb_data;
          state_d = PUSH;
        end else if (wd_expired) begin
          rb_d    = TIMEOUT_VALUE;
          state_d = PUSH;
        end
      end
      PUSH: begin
        if (!res_full) begin
          res_push = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state, latched command word and captured readback
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      rb_q    <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rb_q    <= rb_d;
    end
  end

endmodule
